// File: rtl/maf_pkg.sv
// Shared constants and types for the linear-interpolating upsampler.
package maf_pkg;
  localparam int N_BITS = 32;
  localparam int SHIFT  = 2;
  localparam int ACC_W  = N_BITS + SHIFT;

  typedef enum logic [1:0] {
    EMPTY,
    IDLE,
    RUN
  } state_t;
endpackage

// File: rtl/maf_interp_acc.sv
// Ramp generator: holds the scaled accumulator, the per-step delta and the step phase.
module interp_acc
  import maf_pkg::*;
#(
  parameter int N_BITS = maf_pkg::N_BITS,
  parameter int SHIFT  = maf_pkg::SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [N_BITS-1:0] base,
  input  logic [N_BITS-1:0] sample,
  output logic [N_BITS-1:0] y,
  output logic [N_BITS-1:0] end_val,
  output logic              last
);
  localparam int ACC_W = N_BITS + SHIFT;

  logic [ACC_W-1:0]         acc_reg;
  logic [ACC_W-1:0]         acc_step;
  logic signed [N_BITS:0]   delta_reg;
  logic [SHIFT-1:0]         phase_reg;

  // Modular add is exact: the true sum always stays within [0, L*(2^N_BITS-1)].
  assign acc_step = acc_reg + ACC_W'(delta_reg);
  assign y        = acc_reg[ACC_W-1:SHIFT];
  // On the final step acc_step equals sample*L, so this yields the segment end value.
  assign end_val  = acc_step[ACC_W-1:SHIFT];
  assign last     = &phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      delta_reg <= '0;
      phase_reg <= '0;
    end else if (load) begin
      acc_reg   <= {base, {SHIFT{1'b0}}};
      delta_reg <= $signed({1'b0, sample}) - $signed({1'b0, base});
      phase_reg <= '0;
    end else if (step) begin
      acc_reg   <= acc_step;
      phase_reg <= phase_reg + 1'b1;
    end
  end
endmodule

// File: rtl/maf_interp.sv
// Linear-interpolating upsampler: each input sample yields 2^SHIFT outputs ramping from the previous one.
module maf_interp
  import maf_pkg::*;
#(
  parameter int N_BITS = maf_pkg::N_BITS,
  parameter int SHIFT  = maf_pkg::SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] data_in,
  input  logic              we,
  output logic              out_valid,
  output logic [N_BITS-1:0] data_out,
  output logic              underrun
);
  state_t            state_reg;
  logic [N_BITS-1:0] prev_reg;
  logic [N_BITS-1:0] y;
  logic [N_BITS-1:0] end_val;
  logic              last;
  logic              accept;
  logic              load;
  logic              step;
  logic [N_BITS-1:0] base;

  assign in_ready = (state_reg != RUN) || (last && we);
  assign accept   = in_valid && in_ready;
  assign step     = (state_reg == RUN) && we;
  // In RUN an accept can only happen on the closing step, so the new segment starts at its end value.
  assign load     = accept && (state_reg != EMPTY);
  assign base     = (state_reg == RUN) ? end_val : prev_reg;

  interp_acc #(
    .N_BITS(N_BITS),
    .SHIFT (SHIFT)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .base   (base),
    .sample (data_in),
    .y      (y),
    .end_val(end_val),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      prev_reg  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            prev_reg  <= data_in;
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          underrun <= we;
          if (accept) state_reg <= RUN;
        end
        RUN: begin
          if (we) begin
            data_out  <= y;
            out_valid <= 1'b1;
            if (last) begin
              prev_reg <= end_val;
              if (!accept) state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_maf_interp.sv
// Directed bench for maf_interp: ramps, rounding, streaming, sparse strobe and mid-run reset.
module tb_maf_interp;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        we;
  logic        out_valid;
  logic [31:0] data_out;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  maf_interp dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .we       (we),
    .out_valid(out_valid),
    .data_out (data_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; we = 1'b0; data_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic prime_and_load(input logic [31:0] a, input logic [31:0] b);
    do_reset();
    we = 1'b0; in_valid = 1'b1; data_in = a;
    tick();
    data_in = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (data_out !== 32'd0) begin fails++; $display("FAIL reset_data_out got %h want %h", data_out, 32'd0); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", underrun); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    $display("[TB] reset: data_out=%h out_valid=%b in_ready=%b", data_out, out_valid, in_ready);
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'd100, 32'd125, 32'd150, 32'd175};
    do_reset();
    we = 1'b1; in_valid = 1'b1; data_in = 32'd100;
    tick();
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL basic_empty_underrun got %b want 0", underrun); end
    data_in = 32'd200;
    tick();
    in_valid = 1'b0;
    tests++; if (underrun !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_accept_underrun got u=%b v=%b want u=1 v=0", underrun, out_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || data_out !== exp[k]) begin
        fails++; $display("FAIL basic_out%0d got v=%b %0d want v=1 %0d", k, out_valid, data_out, exp[k]);
      end
      $display("[TB] basic step %0d: data_out=%0d", k, data_out);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (underrun !== 1'b1 || out_valid !== 1'b0 || data_out !== 32'd175) begin
        fails++; $display("FAIL basic_idle%0d got u=%b v=%b %0d want u=1 v=0 175", k, underrun, out_valid, data_out);
      end
    end
  endtask

  task automatic test_descending();
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'hBFFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    prime_and_load(32'hFFFFFFFF, 32'h0);
    we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || data_out !== exp[k]) begin
        fails++; $display("FAIL desc_out%0d got v=%b %h want v=1 %h", k, out_valid, data_out, exp[k]);
      end
      $display("[TB] descending step %0d: data_out=%h", k, data_out);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp [4] = '{32'd0, 32'd0, 32'd1, 32'd2};
    prime_and_load(32'd0, 32'd3);
    we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || data_out !== exp[k]) begin
        fails++; $display("FAIL round_out%0d got v=%b %0d want v=1 %0d", k, out_valid, data_out, exp[k]);
      end
      $display("[TB] rounding step %0d: data_out=%0d", k, data_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    we = 1'b1; in_valid = 1'b1; data_in = 32'd0;
    tick();
    data_in = 32'd4;
    tick();
    data_in = 32'd8;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (in_ready !== ((k % 4) == 3)) begin
        fails++; $display("FAIL b2b_ready%0d got %b want %b", k, in_ready, ((k % 4) == 3));
      end
      tick();
      if (k == 3) in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || data_out !== 32'(k)) begin
        fails++; $display("FAIL b2b_out%0d got v=%b %0d want v=1 %0d", k, out_valid, data_out, k);
      end
      $display("[TB] back_to_back step %0d: data_out=%0d in_valid=%b", k, data_out, in_valid);
    end
    tick();
    tests++; if (underrun !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got u=%b v=%b want u=1 v=0", underrun, out_valid); end
  endtask

  task automatic test_sparse_we();
    logic [31:0] exp [4] = '{32'd100, 32'd125, 32'd150, 32'd175};
    int n = 0;
    prime_and_load(32'd100, 32'd200);
    in_valid = 1'b1; data_in = 32'd300;
    for (int c = 0; c < 12; c++) begin
      we = ((c % 3) == 2);
      #1;
      tests++;
      if (in_ready !== (c == 11)) begin
        fails++; $display("FAIL sparse_ready%0d got %b want %b", c, in_ready, (c == 11));
      end
      tick();
      if (c == 11) in_valid = 1'b0;
      tests++;
      if (we) begin
        if (out_valid !== 1'b1 || data_out !== exp[n] || underrun !== 1'b0) begin
          fails++; $display("FAIL sparse_out%0d got v=%b u=%b %0d want v=1 u=0 %0d", n, out_valid, underrun, data_out, exp[n]);
        end
        $display("[TB] sparse cycle %0d: data_out=%0d", c, data_out);
        n++;
      end else if (out_valid !== 1'b0 || underrun !== 1'b0) begin
        fails++; $display("FAIL sparse_gap%0d got v=%b u=%b want v=0 u=0", c, out_valid, underrun);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_mid_reset();
    prime_and_load(32'd100, 32'd200);
    we = 1'b1;
    tick();
    tick();
    tests++; if (data_out !== 32'd125) begin fails++; $display("FAIL midrst_pre got %0d want 125", data_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (data_out !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_state got %0d v=%b r=%b want 0 v=0 r=1", data_out, out_valid, in_ready);
    end
    $display("[TB] mid_reset: data_out=%0d in_ready=%b", data_out, in_ready);
    in_valid = 1'b1; data_in = 32'd50;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_quiet%0d got v=%b want 0", k, out_valid); end
    end
    in_valid = 1'b1; data_in = 32'd60;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || data_out !== 32'd50) begin fails++; $display("FAIL midrst_out0 got v=%b %0d want v=1 50", out_valid, data_out); end
    tick();
    tests++; if (out_valid !== 1'b1 || data_out !== 32'd52) begin fails++; $display("FAIL midrst_out1 got v=%b %0d want v=1 52", out_valid, data_out); end
    $display("[TB] mid_reset resume: data_out=%0d", data_out);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; we = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    test_descending();
    test_rounding();
    test_back_to_back();
    test_sparse_we();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/maf_interp.md
# maf_interp

Linear-interpolating upsampler, the transmit-side counterpart of the moving-average filter. It accepts 32-bit unsigned samples at a low rate. For every input sample it emits 2^SHIFT (4) output samples that ramp linearly from the previous input to the current one. It sits between the sonar pulse/waveform source and the DAC-rate sample path, driven by the same per-sample write-enable strobe style as the receive filter.

## Interface
- N_BITS, 32: sample width (unsigned).
- SHIFT, 2: log2 of the interpolation factor; factor L = 2^SHIFT = 4.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  data_in holds a valid sample.
- in_ready  out  1  block accepts data_in this cycle. Combinational. Transfer occurs when in_valid & in_ready.
- data_in  in  N_BITS  input sample.
- we  in  1  output-rate strobe. One output step is produced per cycle with we high.
- out_valid  out  1  registered; one-cycle pulse per emitted sample.
- data_out  out  N_BITS  registered interpolated sample. Holds its last value between pulses.
- underrun  out  1  registered; one-cycle pulse when we is high but no segment is active (IDLE state).

## Operation
- Registers:
  - state: EMPTY / IDLE / RUN.
  - prev: N_BITS.
  - delta: signed N_BITS+1, equal to sample - prev.
  - acc: unsigned N_BITS+SHIFT. acc always lies in [0, L·(2^N_BITS−1)], so it never overflows.
  - phase: SHIFT bits.
- EMPTY (reset state): in_ready=1. The first accepted sample loads prev and moves to IDLE. No output is produced. we is ignored; no underrun is flagged.
- IDLE: in_ready=1. An accepted sample x sets:
  - delta ← x − prev
  - acc ← prev << SHIFT
  - phase ← 0
  - state → RUN

  we in IDLE, including the accept cycle: underrun pulses, out_valid=0, data_out unchanged.
- RUN, on each edge with we=1:
  - data_out ← acc[N_BITS+SHIFT−1:SHIFT] (floor of acc/L)
  - out_valid ← 1
  - acc ← acc + delta (sign-extended)
  - phase ← phase+1

  Edges with we=0 change nothing and give out_valid=0.
- Emitted sequence for a segment prev→x: y_k = prev + floor(k·(x−prev)/L), k = 0..L−1. After L steps acc = x·L exactly.
- End of segment, on an edge in RUN with phase = L−1 and we=1:
  - prev ← x (the segment end value).
  - If a sample x' is accepted on the same edge: delta ← x' − x, acc ← x << SHIFT, phase ← 0, state stays RUN. The output stream has no gaps.
  - Otherwise state → IDLE.
- in_ready in RUN = (phase == L−1) & we. Otherwise 0.
- Reset mid-operation: all registers return to reset values. The next accepted sample only primes prev.

## Timing
- Reset values:
  - state=EMPTY, prev=0, acc=0, delta=0, phase=0.
  - data_out=0, out_valid=0, underrun=0.
  - in_ready=1 (it is combinational from state=EMPTY).
- Latency: with we continuously high, the first output of a segment appears one cycle after the sample-accept edge. It is registered on the first we edge in RUN.
- Sustained throughput: one input per L we-cycles when in_valid is held and we=1.
- in_valid may be held across cycles in which in_ready=0; the sample is not consumed until the handshake completes.
- we during the accept edge in IDLE counts as underrun. Its step is lost, not deferred.

## Structure
- Shared package maf_pkg holds:
  - the N_BITS and SHIFT defaults;
  - the state enum (EMPTY, IDLE, RUN);
  - the derived width constant ACC_W = N_BITS+SHIFT.
- One natural sub-module: interp_acc, which contains acc, delta and phase. It has load, step and output-slice logic. The FSM and handshake stay in maf_interp.

## Test plan
- Reset, accept 100 then 200, we held at 1 → data_out 100, 125, 150, 175 on consecutive out_valid pulses. After that, underrun pulses every cycle.
- Descending segment 0xFFFFFFFF→0 → outputs 0xFFFFFFFF, 0xBFFFFFFF, 0x7FFFFFFF, 0x3FFFFFFF. No overflow or wrap.
- Non-divisible rounding, 0→3 → outputs 0, 0, 1, 2 (floor).
- Streaming 0, 4, 8 with in_valid held and we=1 → outputs 0, 1, 2, 3, 4, 5, 6, 7 on contiguous cycles. in_ready is high only on phase-3 edges.
- we high 1 cycle in 3, segment 100→200 → same values 100, 125, 150, 175, spaced 3 cycles apart. No underrun, and in_ready is not asserted early.
- rst asserted after two outputs of segment 100→200 → next cycle data_out=0, out_valid=0, in_ready=1 (EMPTY). Then accepting 50 gives no output until a second sample arrives.
